rll_key_loader: RTL and testbench

- Key-provisioning block for the RLL-locked benchmark netlists.
- Receives a key as a bit-serial valid/ready stream and assembles it in a shadow register.
- Commits the full key atomically onto a parallel bus that drives the locked circuit's keyIn_0_* inputs.
- The locked circuit never sees a partial key, and a bad key can be zeroized.

---
 rtl/rll_key_pkg.sv | 24 ++
 rtl/rll_crc8_serial.sv | 37 +++
 rtl/rll_key_loader.sv | 174 +++++++++++++++++
 tb/tb_rll_key_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_key_pkg.sv
// Shared types and constants for the RLL key loader.
package rll_key_pkg;

    localparam int KEY_W_DEFAULT = 32;
    localparam int CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
    localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } key_ld_state_t;

    // One serial CRC-8 step, MSB-first, non-reflected.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/rll_crc8_serial.sv
// Bit-serial CRC-8 accumulator (poly 0x07, init 0x00, no reflection, no final xor).
module rll_crc8_serial
    import rll_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // clear has priority over a new bit so a restarted frame starts from init
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_INIT;
        end else if (bit_en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader with atomic commit onto the locked circuit's key bus.
// Optional CRC-8 check of each frame is enabled by RLL_KEY_LOADER_KEY_CRC_EN.
//
// state  | meaning
// IDLE   | no frame in progress, committed key held on key_out
// SHIFT  | accepting serial bits (key, then CRC byte when enabled)
// CHECK  | comparing received CRC with computed CRC (CRC build only)
// COMMIT | one cycle: shadow copied to key_out
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEFAULT,
    parameter int CNT_W = $clog2(KEY_W + 8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    input  logic             zeroize,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

`ifdef RLL_KEY_LOADER_KEY_CRC_EN
    localparam logic [CNT_W-1:0] KEY_BITS = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W + CRC_W - 1);
`else
    localparam logic [CNT_W-1:0] LAST_KEY = CNT_W'(KEY_W - 1);
`endif

    key_ld_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             hs;

`ifdef RLL_KEY_LOADER_KEY_CRC_EN
    logic             err_q, err_d;
    logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
    logic [CRC_W-1:0] crc_calc;
    logic             crc_clear;
    logic             crc_bit_en;

    rll_crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .bit_en (crc_bit_en),
        .bit_in (s_data),
        .crc    (crc_calc)
    );
`endif

    assign s_ready = (state_q == SHIFT);
    assign hs      = s_valid && s_ready;

    // next-state and register updates; zeroize beats load_start beats shifting
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
        err_d       = err_q;
        rx_crc_d    = rx_crc_q;
        crc_clear   = 1'b0;
        crc_bit_en  = 1'b0;
`endif
        if (zeroize) begin
            state_d     = IDLE;
            cnt_d       = '0;
            shadow_d    = '0;
            key_out_d   = '0;
            key_valid_d = 1'b0;
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
            rx_crc_d    = '0;
            crc_clear   = 1'b1;
`endif
        end else begin
            // a commit always completes, even when a new frame starts on the same edge
            if (state_q == COMMIT) begin
                key_out_d   = shadow_q;
                key_valid_d = 1'b1;
                state_d     = IDLE;
            end
            if (load_start) begin
                state_d  = SHIFT;
                cnt_d    = '0;
                shadow_d = '0;
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
                err_d     = 1'b0;
                rx_crc_d  = '0;
                crc_clear = 1'b1;
`endif
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (hs) begin
                            cnt_d = cnt_q + CNT_W'(1);
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
                            if (cnt_q < KEY_BITS) begin
                                shadow_d   = {shadow_q[KEY_W-2:0], s_data};
                                crc_bit_en = 1'b1;
                            end else begin
                                rx_crc_d = {rx_crc_q[CRC_W-2:0], s_data};
                            end
                            if (cnt_q == LAST_BIT) begin
                                state_d = CHECK;
                            end
`else
                            shadow_d = {shadow_q[KEY_W-2:0], s_data};
                            if (cnt_q == LAST_KEY) begin
                                state_d = COMMIT;
                            end
`endif
                        end
                    end
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
                    CHECK: begin
                        if (crc_calc == rx_crc_q) begin
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // state and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
            err_q       <= 1'b0;
            rx_crc_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
            err_q       <= err_d;
            rx_crc_q    <= rx_crc_d;
`endif
        end
    end

    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign busy      = (state_q != IDLE);
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader (with or without RLL_KEY_LOADER_KEY_CRC_EN).
module tb_rll_key_loader;

    localparam int KEY_W = 32;
`ifdef RLL_KEY_LOADER_KEY_CRC_EN
    localparam bit CRC_ON = 1'b1;
    localparam int FRAME_BITS = KEY_W + 8;
    localparam int POST = 2;
`else
    localparam bit CRC_ON = 1'b0;
    localparam int FRAME_BITS = KEY_W;
    localparam int POST = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_start;
    logic             s_valid;
    logic             s_ready;
    logic             s_data;
    logic             zeroize;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;

    rll_key_loader #(.KEY_W(KEY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .zeroize    (zeroize),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int hs_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of accepted bits.
    bit               m_active;
    bit               m_chk;
    bit               m_pend;
    bit               m_valid;
    bit               m_err;
    logic [KEY_W-1:0] m_key;
    bit               q_bits[$];

    function automatic logic [KEY_W-1:0] key_from_bits();
        logic [KEY_W-1:0] k = '0;
        for (int i = 0; i < KEY_W; i++) k = k * 2 + KEY_W'(q_bits[i]);
        return k;
    endfunction

    function automatic logic [7:0] rx_crc_from_bits();
        logic [7:0] c = '0;
        for (int i = KEY_W; i < KEY_W + 8; i++) c = c * 2 + 8'(q_bits[i]);
        return c;
    endfunction

    function automatic logic [7:0] ref_crc8(input logic [KEY_W-1:0] k);
        int c = 0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            c = c ^ (int'(k[i]) << 7);
            if ((c & 'h80) != 0) c = ((c << 1) ^ 'h07) & 'hFF;
            else c = (c << 1) & 'hFF;
        end
        return 8'(c);
    endfunction

    task automatic model_reset();
        m_active = 0; m_chk = 0; m_pend = 0; m_valid = 0; m_err = 0; m_key = '0;
        q_bits.delete();
    endtask

    task automatic model_step(input bit ls, input bit zz, input bit v, input bit d);
        if (zz) begin
            m_key = '0; m_valid = 0; m_active = 0; m_pend = 0; m_chk = 0;
            q_bits.delete();
        end else begin
            if (m_pend) begin
                m_key = key_from_bits(); m_valid = 1; m_pend = 0;
            end
            if (ls) begin
                m_active = 1; m_chk = 0; m_err = 0;
                q_bits.delete();
            end else if (m_chk) begin
                m_chk = 0;
                if (ref_crc8(key_from_bits()) == rx_crc_from_bits()) m_pend = 1;
                else m_err = 1;
            end else if (m_active && v) begin
                q_bits.push_back(d);
                if (q_bits.size() == FRAME_BITS) begin
                    m_active = 0;
                    if (CRC_ON) m_chk = 1;
                    else m_pend = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, check ready, advance model, check registered outputs.
    task automatic cyc(input bit ls, input bit zz, input bit v, input bit d);
        load_start = ls; zeroize = zz; s_valid = v; s_data = d;
        #1;
        chk("s_ready", s_ready, m_active);
        if (v && s_ready) hs_cnt++;
        model_step(ls, zz, v, d);
        @(posedge clk); #1;
        chk("key_out", key_out, m_key);
        chk("key_valid", key_valid, m_valid);
        chk("busy", busy, m_active || m_chk || m_pend);
        chk("err", err, m_err);
    endtask

    task automatic send_frame(input logic [KEY_W-1:0] key, input logic [7:0] crc,
                              input int nbits, input int maxgap);
        logic [KEY_W+7:0] frame;
        frame = {key, crc};
        for (int i = 0; i < nbits; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) cyc(0, 0, 0, 1'($urandom));
            cyc(0, 0, 1, frame[KEY_W+7-i]);
        end
    endtask

    task automatic send_key(input logic [KEY_W-1:0] key, input int maxgap);
        send_frame(key, ref_crc8(key), FRAME_BITS, maxgap);
    endtask

    // Idle cycles after the last bit; stray valids must be ignored.
    task automatic finish_frame();
        repeat (POST) cyc(0, 0, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        logic [KEY_W-1:0] rk;
        rst = 1; load_start = 0; zeroize = 0; s_valid = 0; s_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_out", key_out, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 0;

        // back-to-back bits
        cyc(1, 0, 0, 0);
        send_key(32'hA5C30F96, 0);
        finish_frame();
        chk("t1_key", key_out, 32'hA5C30F96);
        chk("t1_valid", key_valid, 1);
        chk("t1_busy", busy, 0);
        chk("t1_keyin0", key_out[0], 0);

        // gapped bits, count handshakes
        cyc(1, 0, 0, 0);
        hs_cnt = 0;
        send_key(32'hA5C30F96, 5);
        finish_frame();
        chk("t2_key", key_out, 32'hA5C30F96);
        chk("t2_hs", hs_cnt, FRAME_BITS);

        // double buffering while a new key streams in
        cyc(1, 0, 0, 0);
        send_key(32'h12345678, 3);
        finish_frame();
        chk("t3_key", key_out, 32'h12345678);

        // zeroize mid-frame
        cyc(1, 0, 0, 0);
        send_frame(32'hCAFEF00D, 8'h00, 10, 1);
        cyc(0, 1, 1, 1);
        chk("t4_key", key_out, 0);
        chk("t4_valid", key_valid, 0);
        chk("t4_ready", s_ready, 0);
        repeat (FRAME_BITS) cyc(0, 0, 1, 1'($urandom));
        chk("t4_key_after", key_out, 0);

        // restart after 20 bits
        cyc(1, 0, 0, 0);
        send_frame(32'h0BADF00D, 8'h00, 20, 2);
        cyc(1, 0, 0, 0);
        send_key(32'hDEADBEEF, 2);
        finish_frame();
        chk("t5_key", key_out, 32'hDEADBEEF);

        // zeroize with load_start
        cyc(1, 0, 0, 0);
        send_frame(32'h11112222, 8'h00, 5, 0);
        cyc(1, 1, 0, 0);
        chk("t5_zz_busy", busy, 0);
        chk("t5_zz_ready", s_ready, 0);

        // load_start on the commit cycle
        cyc(1, 0, 0, 0);
        send_key(32'h0F0F1234, 0);
        repeat (POST - 1) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t6_key", key_out, 32'h0F0F1234);
        chk("t6_busy", busy, 1);
        send_key(32'h55AA33CC, 1);
        finish_frame();
        chk("t6_key2", key_out, 32'h55AA33CC);

        // random keys and gaps
        for (int n = 0; n < 6; n++) begin
            rk = $urandom;
            cyc(1, 0, 0, 0);
            send_key(rk, int'($urandom_range(0, 3)));
            finish_frame();
            chk("rand_key", key_out, rk);
            repeat (int'($urandom_range(0, 3))) cyc(0, 0, 1'($urandom), 1'($urandom));
        end

`ifdef RLL_KEY_LOADER_KEY_CRC_EN
        cyc(1, 0, 0, 0);
        send_frame(32'h00000001, 8'h07, FRAME_BITS, 1);
        finish_frame();
        chk("crc_good_key", key_out, 32'h00000001);
        chk("crc_good_err", err, 0);

        cyc(1, 0, 0, 0);
        send_frame(32'h00000001, 8'h06, FRAME_BITS, 1);
        finish_frame();
        chk("crc_bad_err", err, 1);
        chk("crc_bad_key", key_out, 32'h00000001);

        cyc(1, 0, 0, 0);
        send_frame(32'hFFFF0000, 8'h06, FRAME_BITS, 0);
        finish_frame();
        chk("crc_bad2_err", err, 1);
        chk("crc_bad2_key", key_out, 32'h00000001);

        cyc(1, 0, 0, 0);
        chk("crc_err_clr", err, 0);
        repeat (3) cyc(0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
